// File: rtl/msg_block_buffer.sv
// msg_block_buffer: gathers a BLAKE2s message byte stream into 64-byte
// blocks held in two ping-pong buffers. Each completed block carries its
// first/last flags and the byte offset t that the compression core needs.
// Bytes that arrive while both buffers are full are dropped, and a sticky
// overflow flag records the loss.
module msg_block_buffer (
  input  logic         clk,
  input  logic         reset,
  input  logic         data_v_i,
  input  logic [7:0]   data_i,
  input  logic [5:0]   data_idx_i,
  input  logic         block_first_i,
  input  logic         block_last_i,
  input  logic [63:0]  ll_i,
  output logic         blk_v_o,
  input  logic         blk_ready_i,
  output logic [511:0] blk_o,
  output logic         blk_first_o,
  output logic         blk_last_o,
  output logic [63:0]  t_o,
  output logic         overflow_o
);

  // Two block buffers, each with its own first/last flags and t value.
  logic [511:0] r_buf   [2];
  logic         r_first [2];
  logic         r_last  [2];
  logic [63:0]  r_t     [2];

  logic         r_fill_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic [63:0]  r_t_q;
  logic         r_overflow;

  logic         w_accept;
  logic         w_drop;
  logic         w_pop;
  logic [63:0]  w_t_next;
  logic         w_is_last;
  logic         w_complete;

  // Accept/drop/pop decisions and the running byte offset for this cycle.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through this
    // block leaves one unassigned and no latch is inferred.
    w_accept   = 1'b0;
    w_drop     = 1'b0;
    w_pop      = 1'b0;
    w_t_next   = r_t_q;
    w_is_last  = 1'b0;
    w_complete = 1'b0;

    w_accept = data_v_i && (r_count != 2'd2);
    w_drop   = data_v_i && (r_count == 2'd2);
    w_pop    = (r_count != 2'd0) && blk_ready_i;

    // Byte 0 of the first block restarts the count of bytes seen.
    if (block_first_i && (data_idx_i == 6'd0)) begin
      w_t_next = 64'd1;
    end else begin
      w_t_next = r_t_q + 64'd1;
    end

    // The last block may end short of 64 bytes once the full length is seen.
    w_is_last  = block_last_i && (w_t_next == ll_i);
    w_complete = w_accept && ((data_idx_i == 6'd63) || w_is_last);
  end

  // Buffer contents, stored flags and t values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the buffers are cleared on reset (and on every pop) because
      // the unwritten tail of a short last block must read as zero.
      for (int i = 0; i < 2; i++) begin
        r_buf[i]   <= '0;
        r_first[i] <= 1'b0;
        r_last[i]  <= 1'b0;
        r_t[i]     <= '0;
      end
    end else begin
      // The popped buffer and the fill buffer always differ when both act
      // in one cycle: a pop needs count>0, and then the fill buffer is the
      // other one.
      if (w_pop) begin
        r_buf[r_rd_ptr]   <= '0;
        r_first[r_rd_ptr] <= 1'b0;
        r_last[r_rd_ptr]  <= 1'b0;
        r_t[r_rd_ptr]     <= '0;
      end
      if (w_accept) begin
        r_buf[r_fill_ptr][{data_idx_i, 3'b000} +: 8] <= data_i;
      end
      if (w_complete) begin
        r_first[r_fill_ptr] <= block_first_i;
        r_last[r_fill_ptr]  <= w_is_last;
        r_t[r_fill_ptr]     <= w_is_last ? ll_i : w_t_next;
      end
    end
  end

  // Pointers, occupancy, running offset and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill_ptr <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_t_q      <= '0;
      r_overflow <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register here reads the
      // values from before this edge regardless of statement order.
      if (w_accept) begin
        r_t_q <= w_t_next;
      end
      if (w_complete) begin
        r_fill_ptr <= ~r_fill_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      unique case ({w_complete, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign blk_v_o     = (r_count != 2'd0);
  assign blk_o       = r_buf[r_rd_ptr];
  assign blk_first_o = r_first[r_rd_ptr];
  assign blk_last_o  = r_last[r_rd_ptr];
  assign t_o         = r_t[r_rd_ptr];
  assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_msg_block_buffer.sv
// Bench for msg_block_buffer: a queue-based model of the pending blocks is
// compared with the DUT on every falling edge, and directed scenarios add
// hand-computed literal expectations.
module tb_msg_block_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         data_v_i;
  logic [7:0]   data_i;
  logic [5:0]   data_idx_i;
  logic         block_first_i;
  logic         block_last_i;
  logic [63:0]  ll_i;
  logic         blk_v_o;
  logic         blk_ready_i;
  logic [511:0] blk_o;
  logic         blk_first_o;
  logic         blk_last_o;
  logic [63:0]  t_o;
  logic         overflow_o;

  msg_block_buffer dut (
    .clk           (clk),
    .reset         (reset),
    .data_v_i      (data_v_i),
    .data_i        (data_i),
    .data_idx_i    (data_idx_i),
    .block_first_i (block_first_i),
    .block_last_i  (block_last_i),
    .ll_i          (ll_i),
    .blk_v_o       (blk_v_o),
    .blk_ready_i   (blk_ready_i),
    .blk_o         (blk_o),
    .blk_first_o   (blk_first_o),
    .blk_last_o    (blk_last_o),
    .t_o           (t_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
    logic [63:0]  t;
  } blk_t;

  blk_t         q[$];       // completed blocks waiting for the core
  blk_t         nb;
  logic [511:0] m_fill;     // bytes gathered for the block being filled
  logic [63:0]  m_t;
  logic         m_ovf;
  bit           m_pop;
  bit           m_full;
  bit           m_done;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_fill = '0;
      m_t    = '0;
      m_ovf  = 1'b0;
    end else begin
      m_pop  = (q.size() > 0) && blk_ready_i;
      m_full = (q.size() == 2);
      if (data_v_i && m_full) m_ovf = 1'b1;
      if (m_pop) void'(q.pop_front());
      if (data_v_i && !m_full) begin
        m_fill[data_idx_i * 8 +: 8] = data_i;
        m_t = (block_first_i && data_idx_i == 0) ? 64'd1 : m_t + 64'd1;
        m_done = (data_idx_i == 63) || (block_last_i && m_t == ll_i);
        if (m_done) begin
          nb.data  = m_fill;
          nb.first = block_first_i;
          nb.last  = block_last_i && (m_t == ll_i);
          nb.t     = nb.last ? ll_i : m_t;
          q.push_back(nb);
          m_fill = '0;
        end
      end
    end
  end

  // Compare process: outputs are registered, so sample on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("blk_v", blk_v_o, q.size() > 0);
      check("overflow", overflow_o, m_ovf);
      if (q.size() > 0) begin
        check("blk_data", blk_o, q[0].data);
        check("blk_first", blk_first_o, q[0].first);
        check("blk_last", blk_last_o, q[0].last);
        check("blk_t", t_o, q[0].t);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] d, input logic [5:0] idx, input logic f, input logic l);
    @(negedge clk);
    data_v_i      = 1'b1;
    data_i        = d;
    data_idx_i    = idx;
    block_first_i = f;
    block_last_i  = l;
  endtask

  task automatic idle();
    @(negedge clk);
    data_v_i = 1'b0;
  endtask

  logic [511:0] hold;

  initial begin
    reset = 1'b1; data_v_i = 1'b0; data_i = '0; data_idx_i = '0;
    block_first_i = 1'b0; block_last_i = 1'b0; ll_i = '0; blk_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_v", blk_v_o, 0);
    check("rst_blk", blk_o, 0);
    check("rst_first", blk_first_o, 0);
    check("rst_last", blk_last_o, 0);
    check("rst_t", t_o, 0);
    check("rst_ovf", overflow_o, 0);
    reset = 1'b0;

    // Single full block.
    blk_ready_i = 1'b1; ll_i = 64'd64;
    for (int i = 0; i < 64; i++) send(8'(i), 6'(i), 1'b1, 1'b1);
    idle();
    check("sb_v", blk_v_o, 1);
    check("sb_b0", blk_o[7:0], 8'h00);
    check("sb_b63", blk_o[511:504], 8'h3F);
    check("sb_first", blk_first_o, 1);
    check("sb_last", blk_last_o, 1);
    check("sb_t", t_o, 64);
    idle();
    check("sb_gone", blk_v_o, 0);

    // Partial last block.
    ll_i = 64'd3;
    send(8'hAA, 6'd0, 1'b1, 1'b1);
    send(8'hBB, 6'd1, 1'b1, 1'b1);
    send(8'hCC, 6'd2, 1'b1, 1'b1);
    idle();
    check("pl_blk", blk_o, 512'hCCBBAA);
    check("pl_t", t_o, 3);
    check("pl_last", blk_last_o, 1);
    idle();

    // Non-sequential indices still write and still count.
    ll_i = 64'd5;
    send(8'h11, 6'd0, 1'b1, 1'b1);
    send(8'h22, 6'd10, 1'b1, 1'b1);
    send(8'h33, 6'd20, 1'b1, 1'b1);
    send(8'h44, 6'd30, 1'b1, 1'b1);
    send(8'h55, 6'd40, 1'b1, 1'b1);
    idle();
    check("ns_b10", blk_o[87:80], 8'h22);
    check("ns_b40", blk_o[327:320], 8'h55);
    check("ns_t", t_o, 5);
    idle();

    // Two-block message under back-pressure.
    blk_ready_i = 1'b0; ll_i = 64'd100;
    for (int i = 0; i < 64; i++) send(8'(i) ^ 8'h5A, 6'(i), 1'b1, 1'b0);
    for (int i = 0; i < 36; i++) send(8'(i + 1), 6'(i), 1'b0, 1'b1);
    idle();
    check("tb1_t", t_o, 64);
    check("tb1_first", blk_first_o, 1);
    check("tb1_last", blk_last_o, 0);
    hold = blk_o;
    repeat (3) idle();
    check("tb1_hold", blk_o, hold);
    check("tb1_hold_t", t_o, 64);
    blk_ready_i = 1'b1;
    idle();
    check("tb2_t", t_o, 100);
    check("tb2_first", blk_first_o, 0);
    check("tb2_last", blk_last_o, 1);
    check("tb2_b0", blk_o[7:0], 8'h01);
    check("tb2_tail", blk_o[511:288], 0);
    idle();

    // Overflow: both buffers full, then bytes are dropped.
    blk_ready_i = 1'b0; ll_i = 64'd128;
    for (int i = 0; i < 64; i++) send(8'(i), 6'(i), 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) send(8'h80 | 8'(i), 6'(i), 1'b0, 1'b1);
    send(8'hEE, 6'd5, 1'b0, 1'b0);
    idle();
    check("ov_flag", overflow_o, 1);
    check("ov_v", blk_v_o, 1);
    check("ov_t", t_o, 64);
    send(8'hDD, 6'd6, 1'b0, 1'b0);
    blk_ready_i = 1'b1;
    idle();
    check("ov_blkB_t", t_o, 128);
    check("ov_blkB_b5", blk_o[47:40], 8'h85);
    check("ov_blkB_b6", blk_o[55:48], 8'h86);
    idle();
    check("ov_drained", blk_v_o, 0);
    ll_i = 64'd129;
    send(8'h77, 6'd0, 1'b0, 1'b1);
    idle();
    check("ov_tq_t", t_o, 129);
    check("ov_tq_blk", blk_o, 512'h77);
    check("ov_sticky", overflow_o, 1);
    idle();

    // Completion and pop in the same cycle.
    blk_ready_i = 1'b0; ll_i = 64'd1000;
    for (int i = 0; i < 64; i++) send(8'(i), 6'(i), 1'b1, 1'b0);
    for (int i = 0; i < 63; i++) send(8'hC0 ^ 8'(i), 6'(i), 1'b0, 1'b0);
    send(8'h3C, 6'd63, 1'b0, 1'b0);
    blk_ready_i = 1'b1;
    idle();
    blk_ready_i = 1'b0;
    check("sim_v", blk_v_o, 1);
    check("sim_t", t_o, 128);
    check("sim_first", blk_first_o, 0);
    check("sim_b63", blk_o[511:504], 8'h3C);
    idle();
    check("sim_count1", blk_v_o, 1);
    blk_ready_i = 1'b1;
    idle();
    check("sim_empty", blk_v_o, 0);

    // Reset in the middle of a block, with a byte offered on the reset edge.
    blk_ready_i = 1'b0; ll_i = 64'd64;
    for (int i = 0; i < 30; i++) send(8'(i), 6'(i), 1'b1, 1'b0);
    send(8'h99, 6'd30, 1'b0, 1'b0);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    check("rm_v", blk_v_o, 0);
    check("rm_ovf", overflow_o, 0);
    blk_ready_i = 1'b1;
    for (int i = 0; i < 64; i++) send(8'hF0 ^ 8'(i), 6'(i), 1'b1, 1'b1);
    idle();
    check("rm_new_v", blk_v_o, 1);
    check("rm_new_t", t_o, 64);
    check("rm_new_b1", blk_o[15:8], 8'hF1);
    check("rm_new_b30", blk_o[247:240], 8'hEE);
    repeat (2) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
